paralelo_serial_tx: RTL and testbench

//  Parallel-to-serial transmit stage feeding serial_paralelo (output drives its

---
 rtl/paralelo_serial_tx_if.sv | 34 +++
 rtl/paralelo_serial_tx.sv | 118 +++++++++++
 tb/tb_paralelo_serial_tx.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/paralelo_serial_tx_if.sv
// Byte-in / bit-out bundle between a byte source and the parallel-to-serial stage.
// The slave modport is the transmitter; the master modport is the source/observer.
interface paralelo_serial_tx_if;
  logic [7:0] data_in;
  logic       push_in;
  logic       data_paralelo_serial;
  logic       active_tx;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;
  logic       byte_strobe;

  modport master (
    output data_in,
    output push_in,
    input  data_paralelo_serial,
    input  active_tx,
    input  fifo_full,
    input  fifo_empty,
    input  overflow,
    input  byte_strobe
  );

  modport slave (
    input  data_in,
    input  push_in,
    output data_paralelo_serial,
    output active_tx,
    output fifo_full,
    output fifo_empty,
    output overflow,
    output byte_strobe
  );
endinterface

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmitter: byte FIFO, comma sync preamble after reset,
// then FIFO bytes MSB-first with comma filler whenever the FIFO is empty.
module paralelo_serial_tx #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         SYNC_BC    = 4,
  parameter logic [7:0] COMMA      = 8'hBC
) (
  input  logic                 i_clk_32f,
  input  logic                 i_reset,
  paralelo_serial_tx_if.slave  if_tx
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SYN_W = (SYNC_BC > 0) ? $clog2(SYNC_BC + 1) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [SYN_W-1:0] SYNC_C  = SYN_W'(SYNC_BC);

  typedef enum logic {ST_SYNC, ST_ACTIVE} state_t;
  state_t r_state, w_state_next;

  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shreg;
  logic [SYN_W-1:0] r_sync_cnt;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_full;
  logic             r_empty;
  logic             r_overflow;
  logic             r_serial;
  logic             r_strobe;

  logic       w_load;
  logic       w_push_ok;
  logic       w_pop;
  logic       w_sync_inc;
  logic [7:0] w_byte;

  assign w_load    = (r_bit_cnt == 3'd0);
  assign w_push_ok = if_tx.push_in && !r_full;

  always_ff @(posedge i_clk_32f) begin
    if (!i_reset) r_state <= ST_SYNC;
    else          r_state <= w_state_next;
  end

  // The edge that completes the preamble already selects from the FIFO.
  always_comb begin
    w_state_next = r_state;
    w_byte       = COMMA;
    w_pop        = 1'b0;
    w_sync_inc   = 1'b0;
    if (w_load) begin
      if (r_state == ST_ACTIVE || r_sync_cnt == SYNC_C) begin
        w_state_next = ST_ACTIVE;
        if (!r_empty) begin
          w_byte = r_mem[r_rd_ptr];
          w_pop  = 1'b1;
        end
      end else begin
        w_sync_inc = 1'b1;
      end
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !w_pop)      w_count_next = r_count + 1'b1;
    else if (!w_push_ok && w_pop) w_count_next = r_count - 1'b1;
  end

  always_ff @(posedge i_clk_32f) begin
    if (!i_reset) begin
      r_bit_cnt  <= 3'd0;
      r_shreg    <= 8'd0;
      r_sync_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_serial   <= 1'b0;
      r_strobe   <= 1'b0;
    end else begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_sync_inc) r_sync_cnt <= r_sync_cnt + 1'b1;
      if (w_load) begin
        r_shreg  <= w_byte;
        r_serial <= w_byte[7];
        r_strobe <= 1'b1;
      end else begin
        r_serial <= r_shreg[3'd7 - r_bit_cnt];
        r_strobe <= 1'b0;
      end
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_full  <= (w_count_next == DEPTH_C);
      r_empty <= (w_count_next == '0);
      // Judged on the pre-edge full flag, so a same-edge pop does not rescue it.
      if (if_tx.push_in && r_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk_32f) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= if_tx.data_in;
  end

  assign if_tx.data_paralelo_serial = r_serial;
  assign if_tx.active_tx            = (r_state == ST_ACTIVE);
  assign if_tx.fifo_full            = r_full;
  assign if_tx.fifo_empty           = r_empty;
  assign if_tx.overflow             = r_overflow;
  assign if_tx.byte_strobe          = r_strobe;
endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Directed bench for paralelo_serial_tx: a queue-based model of the byte stream
// is checked every cycle, plus literal expectations on received bytes and flags.
module tb_paralelo_serial_tx;
  localparam logic [7:0] COMMA = 8'hBC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  paralelo_serial_tx_if bus ();

  paralelo_serial_tx #(
    .FIFO_DEPTH (4),
    .SYNC_BC    (4),
    .COMMA      (COMMA)
  ) dut (
    .i_clk_32f (clk),
    .i_reset   (rst_n),
    .if_tx     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: bytes waiting, byte on the wire, cycles since reset release.
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  int         m_k;
  logic       m_ovf;
  logic       e_out, e_strobe, e_active, e_full, e_empty;

  logic [7:0] rx_shift;
  logic [7:0] rx_bytes [32];
  logic [7:0] tx_tbl [10];

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (k=%0d)", name, act, exp, m_k);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare();
    chk1("serial",      bus.data_paralelo_serial, e_out);
    chk1("byte_strobe", bus.byte_strobe,          e_strobe);
    chk1("active_tx",   bus.active_tx,            e_active);
    chk1("fifo_full",   bus.fifo_full,            e_full);
    chk1("fifo_empty",  bus.fifo_empty,           e_empty);
    chk1("overflow",    bus.overflow,             m_ovf);
  endtask

  // Expected outputs after the edge numbered m_k, given this cycle's push.
  task automatic model_edge(input logic push, input logic [7:0] data);
    int ph;
    int n;
    bit pre_full;
    bit pre_empty;
    ph        = m_k % 8;
    n         = m_k / 8;
    pre_full  = (m_q.size() == 4);
    pre_empty = (m_q.size() == 0);
    if (ph == 0) begin
      if (n >= 4 && !pre_empty) m_cur = m_q.pop_front();
      else                      m_cur = COMMA;
      e_strobe = 1'b1;
    end else begin
      e_strobe = 1'b0;
    end
    e_out = m_cur[7 - ph];
    if (push) begin
      if (pre_full) m_ovf = 1'b1;
      else          m_q.push_back(data);
    end
    e_active = (m_k >= 32);
    e_full   = (m_q.size() == 4);
    e_empty  = (m_q.size() == 0);
  endtask

  task automatic capture();
    rx_shift = {rx_shift[6:0], bus.data_paralelo_serial};
    if (m_k % 8 == 7 && m_k / 8 < 32) begin
      rx_bytes[m_k / 8] = rx_shift;
      $display("rx byte n=%0d value=%h", m_k / 8, rx_shift);
    end
  endtask

  task automatic tick(input logic push, input logic [7:0] data);
    bus.push_in = push;
    bus.data_in = data;
    model_edge(push, data);
    @(posedge clk);
    #1;
    compare();
    capture();
    if (push) $display("push k=%0d data=%h", m_k, data);
    m_k++;
    @(negedge clk);
    bus.push_in = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n       = 1'b0;
    bus.push_in = 1'b0;
    bus.data_in = 8'h00;
    m_q.delete();
    m_k      = 0;
    m_ovf    = 1'b0;
    m_cur    = COMMA;
    e_out    = 1'b0;
    e_strobe = 1'b0;
    e_active = 1'b0;
    e_full   = 1'b0;
    e_empty  = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      compare();
      @(negedge clk);
    end
    rst_n = 1'b1;
    $display("reset released after %0d cycles", n);
  endtask

  initial begin
    tx_tbl = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'hF0, 8'h0F};
    rx_shift    = 8'h00;
    bus.push_in = 1'b0;
    bus.data_in = 8'h00;
    @(negedge clk);

    // Sync preamble and idle filler, then one byte pushed just before a load edge.
    do_reset(3);
    for (int i = 0; i < 47; i++) begin
      tick(1'b0, 8'h00);
      if (i == 31) chk1("t1_active_before", bus.active_tx, 1'b0);
      if (i == 32) chk1("t1_active_rise",   bus.active_tx, 1'b1);
      if (i == 40) chk1("t1_strobe_load",   bus.byte_strobe, 1'b1);
      if (i == 41) chk1("t1_strobe_mid",    bus.byte_strobe, 1'b0);
    end
    tick(1'b1, 8'hA5);
    chk1("t2_empty_after_push", bus.fifo_empty, 1'b0);
    tick(1'b0, 8'h00);
    chk1("t2_empty_after_pop", bus.fifo_empty, 1'b1);
    repeat (15) tick(1'b0, 8'h00);
    for (int i = 0; i < 6; i++) chk8("t1_comma", rx_bytes[i], COMMA);
    chk8("t2_data",   rx_bytes[6], 8'hA5);
    chk8("t2_filler", rx_bytes[7], COMMA);

    // FIFO filled during sync, overflow on full, push on a load edge while full.
    do_reset(3);
    tick(1'b1, 8'h11);
    tick(1'b1, 8'h22);
    tick(1'b1, 8'h33);
    tick(1'b1, 8'h44);
    chk1("t3_full", bus.fifo_full, 1'b1);
    tick(1'b1, 8'h55);
    chk1("t4_overflow", bus.overflow, 1'b1);
    chk1("t4_still_full", bus.fifo_full, 1'b1);
    repeat (27) tick(1'b0, 8'h00);
    tick(1'b1, 8'h66);
    chk1("t4_full_after_pop", bus.fifo_full, 1'b0);
    repeat (39) tick(1'b0, 8'h00);
    for (int i = 0; i < 4; i++) chk8("t3_comma", rx_bytes[i], COMMA);
    chk8("t3_b0", rx_bytes[4], 8'h11);
    chk8("t3_b1", rx_bytes[5], 8'h22);
    chk8("t3_b2", rx_bytes[6], 8'h33);
    chk8("t3_b3", rx_bytes[7], 8'h44);
    chk8("t3_filler", rx_bytes[8], COMMA);
    chk1("t4_overflow_held", bus.overflow, 1'b1);

    // Reset landing on bit 3 of a byte while data is queued.
    tick(1'b1, 8'h77);
    tick(1'b1, 8'h88);
    tick(1'b0, 8'h00);
    do_reset(2);
    chk1("t6_serial_zero", bus.data_paralelo_serial, 1'b0);
    chk1("t6_empty",       bus.fifo_empty, 1'b1);
    chk1("t6_ovf_clear",   bus.overflow, 1'b0);

    // Ten bytes across pointer wrap, with push and pop sharing load edges at count 2.
    repeat (38) tick(1'b0, 8'h00);
    tick(1'b1, tx_tbl[0]);
    tick(1'b1, tx_tbl[1]);
    for (int j = 2; j < 10; j++) begin
      tick(1'b1, tx_tbl[j]);
      chk1("t5_not_empty", bus.fifo_empty, 1'b0);
      chk1("t5_not_full",  bus.fifo_full,  1'b0);
      repeat (7) tick(1'b0, 8'h00);
    end
    repeat (24) tick(1'b0, 8'h00);
    for (int i = 0; i < 5; i++) chk8("t6_comma", rx_bytes[i], COMMA);
    for (int j = 0; j < 10; j++) chk8("t5_order", rx_bytes[5 + j], tx_tbl[j]);
    chk8("t5_filler", rx_bytes[15], COMMA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
